// File: rtl/mem_stage_ctrl.sv
// ---------------------------------------------------------------------------
// mem_stage_ctrl
//   Memory-stage controller fed by the EX/MEM pipeline register. ALU results
//   are forwarded to writeback one cycle after acceptance. Loads and stores
//   run a req/ack handshake with a variable-latency data memory. The stage
//   stalls upstream while an access is outstanding. It aborts an access that
//   is not acknowledged within TIMEOUT cycles. A load+store combination is
//   reported as an error.
//
// Ports
//   clk, reset           clock; synchronous active-high reset
//   ex_valid/load/store  EX/MEM slot qualifiers
//   ex_rd, ans_ex        destination index, ALU result / memory address
//   DM_data              store data
//   stall                high whenever an access is outstanding
//   dm_req/we/addr/wdata memory request, held stable until ack or abort
//   dm_ack, dm_rdata     memory completion and read data
//   wb_valid/data/rd     writeback pulse, data and register index
//   mem_err              single-cycle pulse on timeout or illegal op
// ---------------------------------------------------------------------------
module mem_stage_ctrl #(
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned ADDR_W  = 8,
   parameter int unsigned TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ex_valid,
   input  logic              ex_load,
   input  logic              ex_store,
   input  logic [2:0]        ex_rd,
   input  logic [DATA_W-1:0] ans_ex,
   input  logic [DATA_W-1:0] DM_data,
   output logic              stall,
   output logic              dm_req,
   output logic              dm_we,
   output logic [ADDR_W-1:0] dm_addr,
   output logic [DATA_W-1:0] dm_wdata,
   input  logic              dm_ack,
   input  logic [DATA_W-1:0] dm_rdata,
   output logic              wb_valid,
   output logic [DATA_W-1:0] wb_data,
   output logic [2:0]        wb_rd,
   output logic              mem_err
);

   localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic {IDLE, ACCESS} state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [2:0]          rd_q, rd_d;
   logic                wb_valid_q, wb_valid_d;
   logic [DATA_W-1:0]   wb_data_q, wb_data_d;
   logic [2:0]          wb_rd_q, wb_rd_d;
   logic                mem_err_q, mem_err_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         rd_q       <= '0;
         wb_valid_q <= 1'b0;
         wb_data_q  <= '0;
         wb_rd_q    <= '0;
         mem_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         rd_q       <= rd_d;
         wb_valid_q <= wb_valid_d;
         wb_data_q  <= wb_data_d;
         wb_rd_q    <= wb_rd_d;
         mem_err_q  <= mem_err_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      rd_d       = rd_q;
      wb_valid_d = 1'b0;
      wb_data_d  = wb_data_q;
      wb_rd_d    = wb_rd_q;
      mem_err_d  = 1'b0;

      case (state_q)
         IDLE: begin
            if (ex_valid) begin
               if (ex_load && ex_store) begin
                  mem_err_d = 1'b1;
               end else if (ex_load || ex_store) begin
                  state_d = ACCESS;
                  cnt_d   = '0;
                  we_d    = ex_store;
                  addr_d  = ans_ex[ADDR_W-1:0];
                  wdata_d = DM_data;
                  rd_d    = ex_rd;
               end else begin
                  wb_valid_d = 1'b1;
                  wb_data_d  = ans_ex;
                  wb_rd_d    = ex_rd;
               end
            end
         end
         ACCESS: begin
            // Ack is checked before the timeout so an ack on the final
            // allowed cycle still completes normally.
            if (dm_ack) begin
               state_d = IDLE;
               if (!we_q) begin
                  wb_valid_d = 1'b1;
                  wb_data_d  = dm_rdata;
                  wb_rd_d    = rd_q;
               end
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               state_d   = IDLE;
               mem_err_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign stall    = (state_q != IDLE);
   assign dm_req   = (state_q == ACCESS);
   assign dm_we    = we_q;
   assign dm_addr  = addr_q;
   assign dm_wdata = wdata_q;
   assign wb_valid = wb_valid_q;
   assign wb_data  = wb_data_q;
   assign wb_rd    = wb_rd_q;
   assign mem_err  = mem_err_q;

endmodule
